ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_pkg.sv | 32 +++
 rtl/ifetch_unit.sv | 137 +++++++++++++
 tb/tb_ifetch_unit.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared pipeline definitions for the instruction fetch stage: FSM encoding,
// PC step, default reset vector and small address helpers.
package ifetch_pkg;

  localparam int XLEN = 32;

  // Fetch FSM encoding, kept as plain constants for legacy tooling.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  localparam logic [XLEN-1:0] PC_INC           = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instruction word and its fall-through PC as handed to decode.
  typedef struct packed {
    logic [XLEN-1:0] ins;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

  // Fetch addresses are always word aligned.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  // Sequential successor; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] a);
    return a + PC_INC;
  endfunction

endpackage

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: drives the instruction memory and presents one word
// per cycle to the decode register. Optional macro IFETCH_PERF_CNT_EN adds wait_cnt.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic        flush_d,
`ifdef IFETCH_PERF_CNT_EN
  output logic [31:0] wait_cnt,
`endif
  output logic [1:0]  state_dbg
);

  // Memory handshake: imem_req/imem_addr are held stable until the cycle in
  // which imem_ready is high; that cycle completes the transfer and imem_rdata
  // is valid in it. valid_o/stall_f form the decode side: an instruction is
  // consumed on a rising edge where valid_o=1, stall_f=0 and flush_d=0.

  logic [1:0]  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] drop_addr, drop_addr_nxt;
  fetch_pkt_t  pkt, pkt_nxt;
  logic        valid_nxt;
  logic [31:0] pc_plus4;

  assign pc_plus4 = next_pc(pc);

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    drop_addr_nxt = drop_addr;
    pkt_nxt       = pkt;
    valid_nxt     = valid_o;

    case (state)
      ST_IDLE: begin
        state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (!redirect) begin
          if (imem_ready) begin
            pkt_nxt   = '{ins: imem_rdata, pc: pc_plus4};
            valid_nxt = 1'b1;
            pc_nxt    = pc_plus4;
            if (stall_f) begin
              state_nxt = ST_HOLD;
            end
          end else if (!stall_f) begin
            valid_nxt = 1'b0;
          end
        end else if (!imem_ready) begin
          // The old request is already on the bus; finish it and throw it away.
          drop_addr_nxt = pc;
          state_nxt     = ST_DROP;
        end
      end
      ST_HOLD: begin
        if (!stall_f) begin
          valid_nxt = 1'b0;
          state_nxt = ST_REQ;
        end
      end
      ST_DROP: begin
        if (imem_ready) begin
          state_nxt = ST_REQ;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Redirect wins over stall and memory response in every state.
    if (redirect) begin
      pc_nxt    = align_pc(redirect_pc);
      valid_nxt = 1'b0;
      if ((state == ST_IDLE) || (state == ST_HOLD)) begin
        state_nxt = ST_REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      drop_addr <= RESET_PC;
      pkt       <= '0;
      valid_o   <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      drop_addr <= drop_addr_nxt;
      pkt       <= pkt_nxt;
      valid_o   <= valid_nxt;
    end
  end

  // While draining a cancelled request the bus keeps the old address even
  // though pc already points at the redirect target.
  assign imem_req  = (state == ST_REQ) || (state == ST_DROP);
  assign imem_addr = (state == ST_DROP) ? drop_addr : pc;

  assign ins_o     = pkt.ins;
  assign pc_o      = pkt.pc;
  assign flush_d   = redirect | ~valid_o;
  assign state_dbg = state;

`ifdef IFETCH_PERF_CNT_EN
  logic wait_cycle;

  assign wait_cycle = ((state == ST_REQ) && !imem_ready) || (state == ST_DROP);

  // Saturating count of cycles lost waiting on instruction memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (wait_cycle && (wait_cnt != 32'hFFFF_FFFF)) begin
      wait_cnt <= wait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed cycle checks followed by a randomized run
// scored against a transaction-level model of the fetch stream.
module tb_ifetch_unit;
  import ifetch_pkg::*;

  localparam int W = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_f = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ins_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        flush_d;
  logic [1:0]  state_dbg;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] wait_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: {pc_o, ins_o} words decode is still owed, oldest first.
  logic [W-1:0] exp_q[$];

  ifetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall_f     (stall_f),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .ins_o       (ins_o),
    .pc_o        (pc_o),
    .valid_o     (valid_o),
    .flush_d     (flush_d),
`ifdef IFETCH_PERF_CNT_EN
    .wait_cnt    (wait_cnt),
`endif
    .state_dbg   (state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Driver tasks: inputs change 1 time unit after the rising edge, outputs are
  // sampled 1 unit later, well before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    imem_rdata = mem_word(imem_addr);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0]  a;
  logic         prev;
  logic [31:0]  exp_fetch;
  logic [31:0]  cur_addr;
  logic [31:0]  inflight_addr;
  logic         inflight;
  logic         discard;
  logic         exp_valid;
  logic [W-1:0] item;
  int           accepts;

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b0;
    repeat (2) tick();
    settle();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_ins", ins_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_flush", flush_d, 1);
    chk("rst_state", state_dbg, ST_IDLE);

    // ---------------- back-to-back fetch ----------------
    tick(); rst = 1'b1; imem_ready = 1'b1; settle();
    chk("idle_req", imem_req, 0);
    tick(); settle();
    chk("b2b_addr0", imem_addr, 32'h0);
    chk("b2b_req0", imem_req, 1);
    chk("b2b_valid0", valid_o, 0);
    for (int i = 1; i <= 3; i++) begin
      tick(); settle();
      chk("b2b_addr", imem_addr, 32'(4 * i));
      chk("b2b_pc", pc_o, 32'(4 * i));
      chk("b2b_valid", valid_o, 1);
      chk("b2b_ins", ins_o, mem_word(32'(4 * (i - 1))));
    end

    // ---------------- two-cycle memory latency ----------------
    a = 32'd16;
    prev = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      imem_ready = i[0];
      settle();
      chk("lat_valid", valid_o, prev);
      chk("lat_flush", flush_d, !prev);
      chk("lat_addr", imem_addr, a);
      if (prev) chk("lat_pc", pc_o, a);
      if (imem_ready) a = a + 32'd4;
      prev = imem_ready;
    end

    // ---------------- stall hold ----------------
    tick(); imem_ready = 1'b1; stall_f = 1'b1; imem_rdata = 32'h2008_0005; settle();
    chk("stall_entry_addr", imem_addr, 32'd28);
    for (int i = 0; i < 3; i++) begin
      tick(); imem_ready = 1'b0; settle();
      chk("hold_ins", ins_o, 32'h2008_0005);
      chk("hold_pc", pc_o, 32'd32);
      chk("hold_valid", valid_o, 1);
      chk("hold_req", imem_req, 0);
    end
    tick(); stall_f = 1'b0; settle();
    chk("release_req", imem_req, 0);
    chk("release_flush", flush_d, 0);

    // ---------------- redirect while a request is pending ----------------
    tick(); imem_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h10; settle();
    chk("resume_addr", imem_addr, 32'd32);
    chk("resume_valid", valid_o, 0);
    chk("resume_ins", ins_o, 32'h2008_0005);
    chk("redir_hit_flush", flush_d, 1);
    tick(); redirect = 1'b1; redirect_pc = 32'h40; imem_ready = 1'b0; settle();
    chk("redir_hit_addr", imem_addr, 32'h10);
    chk("redir_hit_ins", ins_o, 32'h2008_0005);
    chk("redir_miss_flush", flush_d, 1);
    tick(); redirect = 1'b0; settle();
    chk("drop_addr", imem_addr, 32'h10);
    chk("drop_req", imem_req, 1);
    tick(); imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF; settle();
    chk("drop_addr_ready", imem_addr, 32'h10);

    // ---------------- redirect and stall together in HOLD ----------------
    tick(); imem_ready = 1'b1; stall_f = 1'b1; settle();
    chk("after_drop_addr", imem_addr, 32'h40);
    chk("after_drop_valid", valid_o, 0);
    chk("after_drop_ins", ins_o, 32'h2008_0005);
    tick(); imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h83; settle();
    chk("hold_redir_req", imem_req, 0);
    chk("hold_redir_valid", valid_o, 1);
    chk("hold_redir_flush", flush_d, 1);
    chk("hold_redir_pc", pc_o, 32'h44);

    // ---------------- PC wrap ----------------
    tick(); stall_f = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_ready = 1'b1; settle();
    chk("hold_redir_addr", imem_addr, 32'h80);
    chk("hold_redir_valid2", valid_o, 0);
    chk("hold_redir_pc2", pc_o, 32'h44);
    chk("hold_redir_ins", ins_o, mem_word(32'h40));
    tick(); redirect = 1'b0; imem_ready = 1'b1; settle();
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick(); imem_ready = 1'b0; settle();
    chk("wrap_pc", pc_o, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_valid", valid_o, 1);
    chk("wrap_ins", ins_o, mem_word(32'hFFFF_FFFC));

    // ---------------- reset mid-transaction ----------------
    rst = 1'b0; settle();
    chk("midrst_req", imem_req, 0);
    chk("midrst_addr", imem_addr, 32'h0);
    chk("midrst_valid", valid_o, 0);
    chk("midrst_ins", ins_o, 0);
    chk("midrst_pc", pc_o, 0);

`ifdef IFETCH_PERF_CNT_EN
    // ---------------- wait counter: 5 REQ waits + 2 DROP cycles ----------------
    tick(); rst = 1'b1; imem_ready = 1'b0; stall_f = 1'b0; redirect = 1'b0; settle();
    chk("perf_rst", wait_cnt, 0);
    repeat (4) begin tick(); settle(); end
    tick(); redirect = 1'b1; redirect_pc = 32'h100; settle();
    tick(); redirect = 1'b0; settle();
    tick(); imem_ready = 1'b1; settle();
    tick(); imem_ready = 1'b0; settle();
    chk("perf_cnt", wait_cnt, 32'd7);
    chk("perf_addr", imem_addr, 32'h100);
`endif

    // ---------------- randomized run against the stream model ----------------
    rst = 1'b0; stall_f = 1'b0; redirect = 1'b0; imem_ready = 1'b0; settle();
    exp_q.delete();
    exp_fetch = 32'h0;
    inflight = 1'b0;
    inflight_addr = '0;
    discard = 1'b0;
    accepts = 0;
    tick(); rst = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      exp_valid   = (exp_q.size() != 0);
      stall_f     = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 11) == 0);
      redirect_pc = $urandom & 32'h0000_0FFF;
      if ($urandom_range(0, 7) == 0) redirect_pc = $urandom;
      imem_ready  = imem_req && ($urandom_range(0, 2) != 0) && !(stall_f && exp_valid);
      settle();

      cur_addr = inflight ? inflight_addr : exp_fetch;
      chk("rnd_valid", valid_o, exp_valid);
      chk("rnd_flush", flush_d, redirect | !exp_valid);
      if (imem_req) chk("rnd_addr", imem_addr, cur_addr);
      if (inflight) chk("rnd_req_held", imem_req, 1);

      if (exp_valid && !stall_f && !redirect) begin
        item = exp_q.pop_front();
        chk("rnd_pc", pc_o, item[63:32]);
        chk("rnd_ins", ins_o, item[31:0]);
        accepts++;
      end

      if (imem_ready) begin
        if (!redirect && !discard) begin
          exp_q.push_back({cur_addr + 32'd4, mem_word(cur_addr)});
          exp_fetch = cur_addr + 32'd4;
        end
        inflight = 1'b0;
        discard  = 1'b0;
      end else if (imem_req && !inflight) begin
        inflight      = 1'b1;
        inflight_addr = cur_addr;
      end

      if (redirect) begin
        exp_q.delete();
        exp_fetch = redirect_pc & 32'hFFFF_FFFC;
        if (inflight) discard = 1'b1;
      end

      tick();
    end
    chk("rnd_accepts_min", (accepts >= 200) ? 32'd1 : 32'd0, 32'd1);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
